// File: rtl/pc_fetch_seq_if.sv
// Fetch-sequencer handshake bundle: control inputs from decode/LUT, fetch address and status outputs.
// call_en, ret_en and stack_err exist only when PC_CALL_STACK_EN is defined.
interface pc_fetch_seq_if #(
  parameter int D  = 12,
  parameter int CW = 16
);
  logic          start;
  logic          stall;
  logic          branch_en;
  logic [D-1:0]  target;
  logic          halt_req;
  logic [D-1:0]  prog_ctr;
  logic          fetch_valid;
  logic          done;
  logic          range_err;
  logic [CW-1:0] instr_count;
`ifdef PC_CALL_STACK_EN
  logic          call_en;
  logic          ret_en;
  logic          stack_err;
`endif

  modport master (
    output start, stall, branch_en, target, halt_req,
`ifdef PC_CALL_STACK_EN
    output call_en, ret_en,
    input  stack_err,
`endif
    input  prog_ctr, fetch_valid, done, range_err, instr_count
  );

  modport slave (
    input  start, stall, branch_en, target, halt_req,
`ifdef PC_CALL_STACK_EN
    input  call_en, ret_en,
    output stack_err,
`endif
    output prog_ctr, fetch_valid, done, range_err, instr_count
  );
endinterface

// File: rtl/pc_fetch_seq.sv
// Fetch-stage program-counter sequencer: IDLE/RUN/HALT control, relative jumps, retire counting.
// Optional return-address stack enabled by defining PC_CALL_STACK_EN.
module pc_fetch_seq #(
  parameter int D          = 12,
  parameter int PROG_DEPTH = 1024,
  parameter int START_ADDR = 0,
  parameter int CW         = 16,
  parameter int RAS_DEPTH  = 4
) (
  input logic          clk,
  input logic          reset,
  pc_fetch_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [D:0]   DEPTH_EXT = (D+1)'(PROG_DEPTH);
  localparam logic [D-1:0] LAST_ADDR = D'(PROG_DEPTH - 1);
  localparam logic [D-1:0] START_PC  = D'(START_ADDR);

  state_t        state_q, state_d;
  logic [D-1:0]  progCtr_q, progCtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rangeErr_q, rangeErr_d;

  logic          retire;
  logic          takeSeq;
  logic          takeBranch;
  logic [D-1:0]  seqPc;
  logic [D-1:0]  branchPc;

`ifdef PC_CALL_STACK_EN
  localparam int SPW = $clog2(RAS_DEPTH + 1);

  logic [SPW-1:0] sp_q, sp_d;
  logic [D-1:0]   stack_q [RAS_DEPTH];
  logic [D-1:0]   stack_d [RAS_DEPTH];
  logic           stackErr_q, stackErr_d;
  logic [D-1:0]   popVal;
`endif

  assign seqPc    = progCtr_q + D'(1);
  assign branchPc = progCtr_q + bus.target;

`ifdef PC_CALL_STACK_EN
  // Top-of-stack read without indexing by the wider pointer
  always_comb begin
    popVal = '0;
    for (int i = 0; i < RAS_DEPTH; i++) begin
      if (SPW'(i) + SPW'(1) == sp_q) popVal = stack_q[i];
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    progCtr_d  = progCtr_q;
    count_d    = count_q;
    rangeErr_d = rangeErr_q;
    retire     = 1'b0;
    takeSeq    = 1'b0;
    takeBranch = 1'b0;
`ifdef PC_CALL_STACK_EN
    sp_d       = sp_q;
    stack_d    = stack_q;
    stackErr_d = stackErr_q;
`endif

    unique case (state_q)
      IDLE, HALT: begin
        if (bus.start) begin
          state_d    = RUN;
          progCtr_d  = START_PC;
          count_d    = '0;
          rangeErr_d = 1'b0;
`ifdef PC_CALL_STACK_EN
          sp_d       = '0;
          stackErr_d = 1'b0;
`endif
        end
      end
      RUN: begin
        if (!bus.stall) begin
          retire = 1'b1;
          if (bus.halt_req) begin
            state_d = HALT;
          end
`ifdef PC_CALL_STACK_EN
          else if (bus.ret_en) begin
            if (sp_q == '0) begin
              stackErr_d = 1'b1;
              takeSeq    = 1'b1;
            end else begin
              progCtr_d = popVal;
              sp_d      = sp_q - SPW'(1);
            end
          end else if (bus.call_en) begin
            if (sp_q == SPW'(RAS_DEPTH)) begin
              stackErr_d = 1'b1;
              takeSeq    = 1'b1;
            end else begin
              for (int i = 0; i < RAS_DEPTH; i++) begin
                if (SPW'(i) == sp_q) stack_d[i] = seqPc;
              end
              sp_d       = sp_q + SPW'(1);
              takeBranch = 1'b1;
            end
          end
`endif
          else if (bus.branch_en) begin
            takeBranch = 1'b1;
          end else begin
            takeSeq = 1'b1;
          end

          // An out-of-range landing still loads the PC so software can see where it went
          if (takeBranch) begin
            progCtr_d = branchPc;
            if ({1'b0, branchPc} >= DEPTH_EXT) begin
              rangeErr_d = 1'b1;
              state_d    = HALT;
            end
          end
          if (takeSeq) begin
            if (progCtr_q == LAST_ADDR) state_d = HALT;
            else                        progCtr_d = seqPc;
          end
          if (count_q != '1) count_d = count_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      progCtr_q  <= '0;
      count_q    <= '0;
      rangeErr_q <= 1'b0;
`ifdef PC_CALL_STACK_EN
      sp_q       <= '0;
      stackErr_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      progCtr_q  <= progCtr_d;
      count_q    <= count_d;
      rangeErr_q <= rangeErr_d;
`ifdef PC_CALL_STACK_EN
      sp_q       <= sp_d;
      stack_q    <= stack_d;
      stackErr_q <= stackErr_d;
`endif
    end
  end

  assign bus.prog_ctr    = progCtr_q;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.done        = (state_q == HALT);
  assign bus.range_err   = rangeErr_q;
  assign bus.instr_count = count_q;
`ifdef PC_CALL_STACK_EN
  assign bus.stack_err   = stackErr_q;
`endif

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Scoreboard bench for pc_fetch_seq: a behavioural model pushes expected outputs per cycle,
// which are popped and compared one edge later. Stack tests run when PC_CALL_STACK_EN is defined.
module tb_pc_fetch_seq;

  localparam int D  = 12;
  localparam int PD = 1024;
  localparam int CW = 16;

  typedef struct {
    logic [D-1:0]  pc;
    logic          fv;
    logic          dn;
    logic          err;
    logic [CW-1:0] cnt;
    logic          serr;
  } expect_t;

  logic clk;
  logic reset;
  pc_fetch_seq_if #(.D(D), .CW(CW)) bus ();

  pc_fetch_seq #(.D(D), .PROG_DEPTH(PD), .START_ADDR(0), .CW(CW), .RAS_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;
  expect_t expQ[$];

  // Reference model state: 0=IDLE 1=RUN 2=HALT
  int           mState;
  logic [D-1:0] mPc;
  int           mCnt;
  logic         mErr;
  logic [D-1:0] mStack [4];
  int           mSp;
  logic         mSerr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelSeq();
    if (mPc == D'(PD - 1)) mState = 2;
    else                   mPc = mPc + 1'b1;
  endtask

  task automatic modelBranch(input logic [D-1:0] tg);
    mPc = mPc + tg;
    if (int'(mPc) >= PD) begin
      mErr   = 1'b1;
      mState = 2;
    end
  endtask

  task automatic modelStep(input logic rst, st, stl, br, input logic [D-1:0] tg,
                           input logic hr, cl, rt);
    if (rst) begin
      mState = 0; mPc = '0; mCnt = 0; mErr = 0; mSp = 0; mSerr = 0;
    end else if (mState != 1) begin
      if (st) begin
        mState = 1; mPc = '0; mCnt = 0; mErr = 0; mSp = 0; mSerr = 0;
      end
    end else if (!stl) begin
      if (mCnt < 65535) mCnt++;
      if (hr) mState = 2;
`ifdef PC_CALL_STACK_EN
      else if (rt) begin
        if (mSp == 0) begin mSerr = 1; modelSeq(); end
        else begin mSp--; mPc = mStack[mSp]; end
      end else if (cl) begin
        if (mSp == 4) begin mSerr = 1; modelSeq(); end
        else begin mStack[mSp] = mPc + 1'b1; mSp++; modelBranch(tg); end
      end
`endif
      else if (br) modelBranch(tg);
      else modelSeq();
    end
  endtask

  task automatic compareCycle();
    expect_t e;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = expQ.pop_front();
    checkOutput("prog_ctr",    32'(bus.prog_ctr),    32'(e.pc));
    checkOutput("fetch_valid", 32'(bus.fetch_valid), 32'(e.fv));
    checkOutput("done",        32'(bus.done),        32'(e.dn));
    checkOutput("range_err",   32'(bus.range_err),   32'(e.err));
    checkOutput("instr_count", 32'(bus.instr_count), 32'(e.cnt));
`ifdef PC_CALL_STACK_EN
    checkOutput("stack_err",   32'(bus.stack_err),   32'(e.serr));
`endif
  endtask

  task automatic applyStimulus(input logic rst, st, stl, br, input logic [D-1:0] tg,
                               input logic hr, input logic cl = 1'b0, input logic rt = 1'b0);
    expect_t e;
    reset         = rst;
    bus.start     = st;
    bus.stall     = stl;
    bus.branch_en = br;
    bus.target    = tg;
    bus.halt_req  = hr;
`ifdef PC_CALL_STACK_EN
    bus.call_en   = cl;
    bus.ret_en    = rt;
`endif
    modelStep(rst, st, stl, br, tg, hr, cl, rt);
    e.pc   = mPc;
    e.fv   = (mState == 1);
    e.dn   = (mState == 2);
    e.err  = mErr;
    e.cnt  = CW'(mCnt);
    e.serr = mSerr;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    compareCycle();
  endtask

  task automatic stepN(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.stall = 0; bus.branch_en = 0; bus.target = '0; bus.halt_req = 0;
`ifdef PC_CALL_STACK_EN
    bus.call_en = 0; bus.ret_en = 0;
`endif
    mState = 0; mPc = '0; mCnt = 0; mErr = 0; mSp = 0; mSerr = 0;

    applyStimulus(1, 0, 0, 0, '0, 0);
    applyStimulus(1, 1, 0, 1, 12'd5, 1);
    checkOutput("reset_pc", 32'(bus.prog_ctr), 32'd0);
    checkOutput("reset_fv", 32'(bus.fetch_valid), 32'd0);

    // Straight-line execution from start
    applyStimulus(0, 1, 0, 0, '0, 0);
    stepN(5);
    checkOutput("t1_pc",  32'(bus.prog_ctr), 32'd5);
    checkOutput("t1_cnt", 32'(bus.instr_count), 32'd5);
    checkOutput("t1_fv",  32'(bus.fetch_valid), 32'd1);

    // Backward and forward relative branches
    stepN(15);
    applyStimulus(0, 0, 0, 1, 12'hFEF, 0);
    checkOutput("t2_back", 32'(bus.prog_ctr), 32'd3);
    applyStimulus(0, 0, 0, 1, 12'd11, 0);
    checkOutput("t2_fwd",  32'(bus.prog_ctr), 32'd14);

    // Start while running is ignored
    applyStimulus(0, 1, 0, 0, '0, 0);
    checkOutput("start_in_run", 32'(bus.prog_ctr), 32'd15);

    // Branch underflow wraps past PROG_DEPTH
    applyStimulus(1, 0, 0, 0, '0, 0);
    applyStimulus(0, 1, 0, 0, '0, 0);
    stepN(2);
    applyStimulus(0, 0, 0, 1, 12'hFE4, 0);
    checkOutput("t3_pc",   32'(bus.prog_ctr), 32'hFE6);
    checkOutput("t3_err",  32'(bus.range_err), 32'd1);
    checkOutput("t3_done", 32'(bus.done), 32'd1);
    applyStimulus(0, 0, 1, 1, 12'd3, 1);

    // Stall beats branch
    applyStimulus(0, 1, 0, 0, '0, 0);
    checkOutput("restart_err", 32'(bus.range_err), 32'd0);
    stepN(7);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 12'd5, 0);
    checkOutput("t4_pc",  32'(bus.prog_ctr), 32'd7);
    checkOutput("t4_cnt", 32'(bus.instr_count), 32'd7);

    // Fall off the end of program memory
    stepN(1016);
    checkOutput("t5_last", 32'(bus.prog_ctr), 32'd1023);
    stepN(1);
    checkOutput("t5_pc",   32'(bus.prog_ctr), 32'd1023);
    checkOutput("t5_done", 32'(bus.done), 32'd1);
    checkOutput("t5_err",  32'(bus.range_err), 32'd0);
    applyStimulus(0, 1, 0, 0, '0, 0);
    checkOutput("t5_restart_pc",   32'(bus.prog_ctr), 32'd0);
    checkOutput("t5_restart_done", 32'(bus.done), 32'd0);

    // Self-loop, halt_req over branch, reset mid-run
    stepN(3);
    applyStimulus(0, 0, 0, 1, 12'd0, 0);
    checkOutput("self_loop", 32'(bus.prog_ctr), 32'd3);
    applyStimulus(0, 0, 0, 1, 12'd9, 1);
    checkOutput("halt_pc",  32'(bus.prog_ctr), 32'd3);
    checkOutput("halt_cnt", 32'(bus.instr_count), 32'd5);
    applyStimulus(0, 1, 0, 0, '0, 0);
    stepN(4);
    applyStimulus(1, 0, 0, 1, 12'd2, 0);
    applyStimulus(0, 0, 0, 0, '0, 0);

`ifdef PC_CALL_STACK_EN
    // Call/return and stack overflow
    applyStimulus(0, 1, 0, 0, '0, 0);
    stepN(10);
    applyStimulus(0, 0, 0, 0, 12'd6, 0, 1, 0);
    checkOutput("t6_call", 32'(bus.prog_ctr), 32'd16);
    applyStimulus(0, 0, 0, 0, '0, 0, 0, 1);
    checkOutput("t6_ret", 32'(bus.prog_ctr), 32'd11);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 12'd1, 0, 1, 0);
    checkOutput("t6_noerr", 32'(bus.stack_err), 32'd0);
    applyStimulus(0, 0, 0, 0, 12'd1, 0, 1, 0);
    checkOutput("t6_serr", 32'(bus.stack_err), 32'd1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, '0, 0, 0, 1);
`endif

    // Randomised mix checked against the model
    applyStimulus(1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0),
                    D'($urandom_range(0, 40)) - D'(20),
                    ($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
